// File: rtl/text_buffer.sv
// text_buffer: 80x30 character cell store feeding the VGA text renderer.
// Accepts ASCII over valid/ready, keeps a cursor, blanks new lines and the
// whole screen as needed, and returns the code for the renderer's current cell.
module text_buffer #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int CW   = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [CW-1:0] wr_char,
  output logic          wr_ready,
  input  logic          clr_req,
  input  logic [9:0]    pixel_x,
  input  logic [8:0]    pixel_y,
  output logic [CW-1:0] char_addr,
  output logic [6:0]    cursor_col,
  output logic [4:0]    cursor_row,
  output logic          busy
);

  localparam int            CELLS     = COLS * ROWS;
  localparam logic [11:0]   LAST_CELL = 12'(CELLS - 1);
  localparam logic [6:0]    LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]    LAST_ROW  = 5'(ROWS - 1);
  localparam logic [CW-1:0] CH_BLANK  = CW'(7'h00);
  localparam logic [CW-1:0] CH_BS     = CW'(7'h08);
  localparam logic [CW-1:0] CH_LF     = CW'(7'h0A);
  localparam logic [CW-1:0] CH_CR     = CW'(7'h0D);
  localparam logic [CW-1:0] CH_FIRST  = CW'(7'h20);
  localparam logic [CW-1:0] CH_LAST   = CW'(7'h7E);

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_LINECLR = 2'd2
  } state_t;

  // row*80 + col built from shifts so no multiplier is inferred
  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    cell_addr = ({7'd0, row} << 6) + ({7'd0, row} << 4) + {5'd0, col};
  endfunction

  logic [CW-1:0] mem_r [0:CELLS-1];

  state_t        state_r;
  logic [11:0]   clr_addr_r;
  logic [6:0]    lc_col_r;
  logic [6:0]    cursor_col_r;
  logic [4:0]    cursor_row_r;
  logic [CW-1:0] char_addr_r;

  logic          wr_ready_s;
  logic          is_print_s;
  logic [4:0]    next_row_s;
  logic          mem_we_s;
  logic [11:0]   mem_waddr_s;
  logic [CW-1:0] mem_wdata_s;
  logic [6:0]    rd_col_s;
  logic [4:0]    rd_row_s;
  logic          rd_in_range_s;
  logic [11:0]   rd_addr_s;
  logic          unused_s;

  assign wr_ready_s    = (state_r == ST_IDLE) & ~clr_req;
  assign is_print_s    = (wr_char >= CH_FIRST) && (wr_char <= CH_LAST);
  assign next_row_s    = (cursor_row_r == LAST_ROW) ? 5'd0 : cursor_row_r + 5'd1;
  assign rd_col_s      = pixel_x[9:3];
  assign rd_row_s      = pixel_y[8:4];
  assign rd_in_range_s = (rd_col_s < 7'(COLS)) && (rd_row_s < 5'(ROWS));
  assign rd_addr_s     = cell_addr(rd_row_s, rd_col_s);
  assign unused_s      = ^{pixel_x[2:0], pixel_y[3:0]};

  assign wr_ready   = wr_ready_s;
  assign busy       = (state_r != ST_IDLE);
  assign char_addr  = char_addr_r;
  assign cursor_col = cursor_col_r;
  assign cursor_row = cursor_row_r;

  // Select the single cell write for this cycle: clear sweep, line blanking or a character
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = 12'd0;
    mem_wdata_s = CH_BLANK;
    case (state_r)
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_addr_r;
      end
      ST_LINECLR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = cell_addr(cursor_row_r, lc_col_r);
      end
      ST_IDLE: begin
        if (wr_valid && wr_ready_s && is_print_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = cell_addr(cursor_row_r, cursor_col_r);
          mem_wdata_s = wr_char;
        end else if (wr_valid && wr_ready_s && (wr_char == CH_BS) && (cursor_col_r != 7'd0)) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = cell_addr(cursor_row_r, cursor_col_r - 7'd1);
        end else begin
          mem_we_s    = 1'b0;
        end
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Cell storage write port (contents are not reset; CLEAR initialises them)
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Renderer read port: one clock of latency, old data on a same-cell write, blank off-screen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char_addr_r <= CH_BLANK;
    end else if (rd_in_range_s) begin
      char_addr_r <= mem_r[rd_addr_s];
    end else begin
      char_addr_r <= CH_BLANK;
    end
  end

  // Control FSM: screen clear, line blanking and cursor handling on each accepted character
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_CLEAR;
      clr_addr_r   <= 12'd0;
      lc_col_r     <= 7'd0;
      cursor_col_r <= 7'd0;
      cursor_row_r <= 5'd0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (clr_addr_r == LAST_CELL) begin
            state_r    <= ST_IDLE;
            clr_addr_r <= 12'd0;
          end else begin
            clr_addr_r <= clr_addr_r + 12'd1;
          end
        end
        ST_LINECLR: begin
          if (lc_col_r == LAST_COL) begin
            state_r  <= ST_IDLE;
            lc_col_r <= 7'd0;
          end else begin
            lc_col_r <= lc_col_r + 7'd1;
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state_r      <= ST_CLEAR;
            clr_addr_r   <= 12'd0;
            cursor_col_r <= 7'd0;
            cursor_row_r <= 5'd0;
          end else if (wr_valid) begin
            if (is_print_s) begin
              if (cursor_col_r == LAST_COL) begin
                cursor_col_r <= 7'd0;
                cursor_row_r <= next_row_s;
                lc_col_r     <= 7'd0;
                state_r      <= ST_LINECLR;
              end else begin
                cursor_col_r <= cursor_col_r + 7'd1;
              end
            end else if (wr_char == CH_CR) begin
              cursor_col_r <= 7'd0;
            end else if (wr_char == CH_LF) begin
              cursor_col_r <= 7'd0;
              cursor_row_r <= next_row_s;
              lc_col_r     <= 7'd0;
              state_r      <= ST_LINECLR;
            end else if ((wr_char == CH_BS) && (cursor_col_r != 7'd0)) begin
              cursor_col_r <= cursor_col_r - 7'd1;
            end else begin
              cursor_col_r <= cursor_col_r;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r    <= ST_CLEAR;
          clr_addr_r <= 12'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_buffer.sv
// tb_text_buffer: directed checks of clear timing, character placement,
// wrap/line blanking, control codes, clear requests and mid-clear reset.
module tb_text_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [6:0] wr_char;
  logic       wr_ready;
  logic       clr_req;
  logic [9:0] pixel_x;
  logic [8:0] pixel_y;
  logic [6:0] char_addr;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  int checks = 0;
  int failures = 0;

  text_buffer dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_char(wr_char),
    .wr_ready(wr_ready), .clr_req(clr_req), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .char_addr(char_addr), .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Count edges until wr_ready rises (bounded); also count samples with busy low
  task automatic wait_ready(output int n, output int gaps);
    n = 0;
    gaps = 0;
    while (!wr_ready && n < 5000) begin
      if (!busy) gaps++;
      tick();
      n++;
    end
  endtask

  task automatic send(input logic [6:0] c);
    int n;
    int g;
    wait_ready(n, g);
    check("send_ready", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_char  = c;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_cell(input int col, input int row, output logic [6:0] val);
    pixel_x = 10'(col * 8 + (col % 8));
    pixel_y = 9'(row * 16 + (row % 16));
    tick();
    val = char_addr;
  endtask

  // Count cells in a row range that differ from the given code
  task automatic count_diff(input int row_lo, input int row_hi, input logic [6:0] code, output int bad);
    logic [6:0] v;
    bad = 0;
    for (int r = row_lo; r <= row_hi; r++) begin
      for (int c = 0; c < 80; c++) begin
        read_cell(c, r, v);
        if (v !== code) bad++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g;
    int bad;
    logic [6:0] v;

    reset = 1'b1; wr_valid = 1'b0; wr_char = 7'h00; clr_req = 1'b0;
    pixel_x = 10'd0; pixel_y = 9'd0;
    #3;
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_char_addr", {25'd0, char_addr}, 32'd0);
    check("rst_cursor_col", {25'd0, cursor_col}, 32'd0);
    check("rst_cursor_row", {27'd0, cursor_row}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    wr_valid = 1'b1; wr_char = 7'h5A;
    wait_ready(n, g);
    wr_valid = 1'b0;
    check("clear_len", n, 32'd2400);
    check("clear_busy_gaps", g, 32'd0);
    check("clear_cursor_col", {25'd0, cursor_col}, 32'd0);
    check("clear_cursor_row", {27'd0, cursor_row}, 32'd0);
    count_diff(0, 29, 7'h00, bad);
    check("clear_all_zero", bad, 32'd0);

    // 'J','E' back-to-back and the 1-clk read latency
    wr_valid = 1'b1; wr_char = 7'h4A;
    check("j_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    check("j_col", {25'd0, cursor_col}, 32'd1);
    wr_char = 7'h45;
    check("e_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
    check("e_col", {25'd0, cursor_col}, 32'd2);
    pixel_x = 10'd3; pixel_y = 9'd5;
    tick();
    check("rd_j", {25'd0, char_addr}, 32'h4A);
    pixel_x = 10'd12; pixel_y = 9'd15;
    #1;
    check("rd_latency_hold", {25'd0, char_addr}, 32'h4A);
    tick();
    check("rd_e", {25'd0, char_addr}, 32'h45);

    // 80 printable characters on row 0, wrap to row 1
    send(7'h0D);
    check("cr_col", {25'd0, cursor_col}, 32'd0);
    for (int i = 0; i < 80; i++) send(7'(8'h41 + 8'(i % 26)));
    check("wrap_col", {25'd0, cursor_col}, 32'd0);
    check("wrap_row", {27'd0, cursor_row}, 32'd1);
    check("wrap_busy", {31'd0, busy}, 32'd1);
    wait_ready(n, g);
    check("lineclr_len", n, 32'd80);
    check("lineclr_busy_gaps", g, 32'd0);
    count_diff(1, 1, 7'h00, bad);
    check("row1_blank", bad, 32'd0);
    read_cell(0, 0, v);
    check("row0_col0", {25'd0, v}, 32'h41);
    read_cell(79, 0, v);
    check("row0_col79", {25'd0, v}, 32'h42);
    send(7'h51);
    read_cell(0, 1, v);
    check("char81_cell", {25'd0, v}, 32'h51);
    check("char81_col", {25'd0, cursor_col}, 32'd1);
    check("char81_row", {27'd0, cursor_row}, 32'd1);

    // Row 0 filled with 'A', cursor to row 29, LF wraps and blanks row 0
    send(7'h0D);
    for (int i = 0; i < 29; i++) send(7'h0A);
    check("lf_wrap_row0", {27'd0, cursor_row}, 32'd0);
    for (int i = 0; i < 80; i++) send(7'h41);
    for (int i = 0; i < 28; i++) send(7'h0A);
    wait_ready(n, g);
    check("at_row29", {27'd0, cursor_row}, 32'd29);
    count_diff(0, 0, 7'h41, bad);
    check("row0_all_a", bad, 32'd0);
    send(7'h0A);
    check("lf29_row", {27'd0, cursor_row}, 32'd0);
    check("lf29_col", {25'd0, cursor_col}, 32'd0);
    wait_ready(n, g);
    check("lf29_lineclr_len", n, 32'd80);
    count_diff(0, 0, 7'h00, bad);
    check("row0_blanked", bad, 32'd0);

    // Backspace, CR and ignored codes
    send(7'h58);
    send(7'h0D);
    read_cell(0, 0, v);
    check("cr_no_write", {25'd0, v}, 32'h58);
    send(7'h08);
    check("bs0_col", {25'd0, cursor_col}, 32'd0);
    check("bs0_row", {27'd0, cursor_row}, 32'd0);
    read_cell(0, 0, v);
    check("bs0_no_write", {25'd0, v}, 32'h58);
    send(7'h59);
    send(7'h01);
    check("ignored_col", {25'd0, cursor_col}, 32'd1);
    check("ignored_ready", {31'd0, wr_ready}, 32'd1);
    send(7'h08);
    check("bs_col", {25'd0, cursor_col}, 32'd0);
    read_cell(0, 0, v);
    check("bs_blank", {25'd0, v}, 32'h00);

    // clr_req beats a simultaneous character
    send(7'h4B);
    send(7'h4C);
    wr_valid = 1'b1; wr_char = 7'h4D; clr_req = 1'b1;
    #1;
    check("clr_blocks_ready", {31'd0, wr_ready}, 32'd0);
    tick();
    wr_valid = 1'b0; clr_req = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd1);
    check("clr_cursor_col", {25'd0, cursor_col}, 32'd0);
    wait_ready(n, g);
    check("clr_len", n, 32'd2400);
    read_cell(2, 0, v);
    check("clr_m_absent", {25'd0, v}, 32'h00);

    // Reset at clear address 1000 restarts a full clear
    send(7'h5A);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 1000; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd1);
    check("midrst_ready", {31'd0, wr_ready}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    wait_ready(n, g);
    check("midrst_clear_len", n, 32'd2400);
    read_cell(0, 0, v);
    check("midrst_cell0", {25'd0, v}, 32'h00);

    // Off-screen reads return blank even when the aliased cell holds data
    send(7'h0A);
    for (int i = 0; i < 8; i++) send(7'h52);
    read_cell(7, 1, v);
    check("r_at_1_7", {25'd0, v}, 32'h52);
    pixel_x = 10'd700; pixel_y = 9'd3;
    tick();
    check("offscreen_x", {25'd0, char_addr}, 32'h00);
    pixel_x = 10'd0; pixel_y = 9'd480;
    tick();
    check("offscreen_y", {25'd0, char_addr}, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
